// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported word memory between the instruction
// fetch requester and the data-access requester. Data wins by default; a
// starvation guard forces a fetch grant after STARVE_LIMIT consecutive data
// grants taken while fetch was waiting. A saturating counter records stall cycles.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    state_t              state_r;
    logic [SC_W-1:0]     starve_r;
    logic                if_ack_r;
    logic                d_ack_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic                i_elig_s;
    logic                d_elig_s;
    logic                stall_s;

    // Memory is word addressed: drop the byte offset of a requester address.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    // Saturating increment of the starvation counter.
    function automatic logic [SC_W-1:0] starve_inc(input logic [SC_W-1:0] c);
        if (c == STARVE_MAX) begin
            return c;
        end else begin
            return c + {{(SC_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Eligibility masks a request during its own ack cycle; stall reflects raw requests.
    always_comb begin
        i_elig_s = start_i & if_req_i & ~if_ack_r;
        d_elig_s = start_i & d_req_i & ~d_ack_r;
        stall_s  = rst_i & ((if_req_i & ~if_ack_r) | (d_req_i & ~d_ack_r));
    end

    // Arbitration FSM: grant, hold the latched access until memory acks, then pulse ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            starve_r    <= {SC_W{1'b0}};
            if_ack_r    <= 1'b0;
            d_ack_r     <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            if_ack_r <= 1'b0;
            d_ack_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_elig_s && (!d_elig_s || (starve_r == STARVE_MAX))) begin
                        state_r     <= GNT_I;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= word_align(if_addr_i);
                        mem_wdata_r <= {DATA_W{1'b0}};
                        starve_r    <= {SC_W{1'b0}};
                    end else if (d_elig_s) begin
                        state_r     <= GNT_D;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= d_we_i;
                        mem_addr_r  <= word_align(d_addr_i);
                        mem_wdata_r <= d_wdata_i;
                        if (!if_req_i) begin
                            starve_r <= {SC_W{1'b0}};
                        end else if (i_elig_s) begin
                            starve_r <= starve_inc(starve_r);
                        end else begin
                            starve_r <= starve_r;
                        end
                    end else begin
                        state_r <= IDLE;
                        if (!if_req_i) begin
                            starve_r <= {SC_W{1'b0}};
                        end else begin
                            starve_r <= starve_r;
                        end
                    end
                end
                GNT_I: begin
                    if (mem_ack_i) begin
                        if_rdata_r <= mem_rdata_i;
                        if_ack_r   <= 1'b1;
                        mem_req_r  <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= GNT_I;
                    end
                end
                GNT_D: begin
                    if (mem_ack_i) begin
                        d_rdata_r <= mem_rdata_i;
                        d_ack_r   <= 1'b1;
                        mem_req_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= GNT_D;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the pipeline is stalled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign if_rdata_o  = if_rdata_r;
    assign if_ack_o    = if_ack_r;
    assign d_rdata_o   = d_rdata_r;
    assign d_ack_o     = d_ack_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign stall_o     = stall_s;
    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester agents push expected accesses
// into scoreboard queues as they drive them; a monitor pops and compares when
// the memory completes an access and when the requester ack follows.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            len;
    } xact_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b1;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr, mem_addr, sat_mem_addr;
    logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [DW-1:0] sat_if_rdata, sat_d_rdata, sat_mem_wdata;
    logic          if_ack, d_ack, mem_req, mem_we, mem_ack, stall;
    logic          sat_if_ack, sat_d_ack, sat_mem_req, sat_mem_we, sat_stall;
    logic [15:0]   stall_cnt;
    logic [3:0]    sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // bench controls
    int   wait_n = 0;
    logic hold_ack = 1'b0;
    logic start_en = 1'b1;
    logic starve_mode = 1'b0;
    logic scramble = 1'b0;
    logic flush = 1'b0;
    int   wcnt = 0;

    req_t  if_stim[$], d_stim[$];
    xact_t if_q[$], d_q[$];
    logic  order_q[$];   // 1 = data grant expected next, 0 = fetch

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_ack_o(d_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .stall_o(stall), .stall_cnt_o(stall_cnt)
    );

    // never granted (start tied low); used only for stall-counter saturation
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(1'b0),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(sat_if_rdata), .if_ack_o(sat_if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(sat_d_rdata), .d_ack_o(sat_d_ack),
        .mem_req_o(sat_mem_req), .mem_we_o(sat_mem_we), .mem_addr_o(sat_mem_addr),
        .mem_wdata_o(sat_mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(1'b0),
        .stall_o(sat_stall), .stall_cnt_o(sat_cnt)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h0000_0004) return 32'h2008_0005;
        else return 32'hC0DE_0000 | a;
    endfunction

    // memory model: ack after wait_n wait cycles, data is a function of the address
    assign mem_ack   = mem_req && !hold_ack && (wcnt >= wait_n);
    assign mem_rdata = mem_fn(mem_addr);
    always @(posedge clk) begin
        if (mem_req && mem_ack) wcnt <= 0;
        else if (mem_req)       wcnt <= wcnt + 1;
        else                    wcnt <= 0;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // fetch requester agent
    initial begin
        req_t r; xact_t e; int n;
        if_req = 1'b0; if_addr = '0;
        forever begin
            if (if_stim.size() != 0 && !flush) begin
                r = if_stim.pop_front();
                if_req = 1'b1; if_addr = r.addr;
                e.addr = r.addr & 32'hFFFF_FFFC; e.we = 1'b0; e.wdata = '0;
                e.rdata = mem_fn(e.addr); e.len = wait_n + 1;
                if_q.push_back(e);
                n = 0;
                do begin @(negedge clk); n++; end while (!if_ack && !flush && n < 200);
                if (!flush) check_val("if_ack_wait", (n < 200), 1);
                @(posedge clk); #1;
                if_req = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // data requester agent
    initial begin
        req_t r; xact_t e; int n;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        forever begin
            if (d_stim.size() != 0 && !flush) begin
                r = d_stim.pop_front();
                d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
                e.addr = r.addr & 32'hFFFF_FFFC; e.we = r.we; e.wdata = r.wdata;
                e.rdata = mem_fn(e.addr); e.len = wait_n + 1;
                d_q.push_back(e);
                n = 0;
                do begin
                    @(negedge clk); n++;
                    if (scramble && n == 2) begin d_addr = 32'h3C; d_wdata = 32'h0; end
                end while (!d_ack && !flush && n < 200);
                if (!flush) check_val("d_ack_wait", (n < 200), 1);
                @(posedge clk); #1;
                d_req = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // monitor: start_i driver, completion scoreboard, ack/rdata checks
    int    run = 0;
    logic  pend_i = 1'b0, pend_d = 1'b0, pend_we = 1'b0;
    logic [DW-1:0] pend_rd = '0;
    initial begin
        xact_t e; logic cur_d, o;
        forever begin
            @(negedge clk);
            cur_d = (order_q.size() != 0) ? order_q[0] : 1'b0;
            start = start_en && !(starve_mode && ((mem_req && mem_ack && cur_d) || d_ack));
            if (!rst_n) begin
                run = 0; pend_i = 1'b0; pend_d = 1'b0;
            end else begin
                check_val("if_ack", if_ack, pend_i);
                check_val("d_ack", d_ack, pend_d);
                if (pend_i) check_val("if_rdata", if_rdata, pend_rd);
                if (pend_d && !pend_we) check_val("d_rdata", d_rdata, pend_rd);
                pend_i = 1'b0; pend_d = 1'b0;
                if (mem_req) begin
                    run++;
                    if (mem_ack) begin
                        check_val("grant_expected", (order_q.size() != 0), 1);
                        if (order_q.size() != 0) begin
                            o = order_q.pop_front();
                            check_val("grant_queue", o ? (d_q.size() != 0) : (if_q.size() != 0), 1);
                            if ((o && d_q.size() != 0) || (!o && if_q.size() != 0)) begin
                                e = o ? d_q.pop_front() : if_q.pop_front();
                                check_val("mem_addr", mem_addr, e.addr);
                                check_val("mem_we", mem_we, e.we);
                                check_val("mem_wdata", mem_wdata, e.wdata);
                                check_val("mem_req_len", run, e.len);
                                pend_i = !o; pend_d = o; pend_we = e.we; pend_rd = e.rdata;
                            end
                        end
                        run = 0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (n < 400 && (if_stim.size() != 0 || d_stim.size() != 0 || if_req || d_req || order_q.size() != 0));
        check_val("idle_wait", (n < 400), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_mem_req();
        int n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 50);
        check_val("mem_req_wait", (n < 50), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        // reset state
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_if_ack", if_ack, 0);
        check_val("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;

        // single fetch, zero-wait memory
        wait_n = 0;
        if_stim.push_back('{addr: 32'h6, we: 1'b0, wdata: 32'h0});
        order_q.push_back(1'b0);
        wait_idle();
        check_val("fetch_stall_cnt", stall_cnt, 2);

        // simultaneous: data write first (3 waits), fetch right after the data ack
        do_reset();
        wait_n = 3; scramble = 1'b1;
        d_stim.push_back('{addr: 32'h10, we: 1'b1, wdata: 32'hDEAD_BEEF});
        if_stim.push_back('{addr: 32'h20, we: 1'b0, wdata: 32'h0});
        order_q.push_back(1'b1); order_q.push_back(1'b0);
        wait_idle();
        scramble = 1'b0;
        check_val("simul_stall_cnt", stall_cnt, 10);

        // starvation guard: four data grants, one fetch, then data resumes
        do_reset();
        wait_n = 0; starve_mode = 1'b1;
        for (int k = 0; k < 6; k++) d_stim.push_back('{addr: 32'h100 + 32'(4*k), we: 1'b0, wdata: 32'h0});
        if_stim.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
        for (int k = 0; k < 4; k++) order_q.push_back(1'b1);
        order_q.push_back(1'b0); order_q.push_back(1'b1); order_q.push_back(1'b1);
        wait_idle();
        starve_mode = 1'b0;

        // start gating with both requests pending, plus counter saturation
        do_reset();
        start_en = 1'b0;
        repeat (2) @(negedge clk);
        wait_n = 1;
        d_stim.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
        if_stim.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
        order_q.push_back(1'b1); order_q.push_back(1'b0);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            check_val("gated_mem_req", mem_req, 0);
            if (i == 11) check_val("sat_cnt_mid", sat_cnt, 10);
        end
        check_val("gated_stall", stall, 1);
        check_val("gated_stall_cnt", stall_cnt, 20);
        check_val("sat_cnt_hold", sat_cnt, 15);
        start_en = 1'b1;
        wait_idle();

        // start dropped mid fetch grant: fetch completes, pending data is not granted
        wait_n = 3;
        if_stim.push_back('{addr: 32'h50, we: 1'b0, wdata: 32'h0});
        order_q.push_back(1'b0);
        wait_mem_req();
        start_en = 1'b0;
        d_stim.push_back('{addr: 32'h54, we: 1'b0, wdata: 32'h0});
        order_q.push_back(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (order_q.size() > 1 && n < 50);
        check_val("gated_fetch_done", (n < 50), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("gated_no_grant", mem_req, 0);
        end
        start_en = 1'b1;
        wait_idle();

        // reset in the middle of a data access
        hold_ack = 1'b1; wait_n = 0;
        d_stim.push_back('{addr: 32'h60, we: 1'b1, wdata: 32'h1234_5678});
        order_q.push_back(1'b1);
        wait_mem_req();
        rst_n = 1'b0; flush = 1'b1;
        #1;
        check_val("midrst_mem_req", mem_req, 0);
        check_val("midrst_mem_we", mem_we, 0);
        check_val("midrst_d_ack", d_ack, 0);
        check_val("midrst_stall_cnt", stall_cnt, 0);
        check_val("midrst_stall", stall, 0);
        check_val("midrst_if_rdata", if_rdata, 0);
        check_val("midrst_d_rdata", d_rdata, 0);
        repeat (3) @(negedge clk);
        check_val("midrst_req_dropped", d_req, 0);
        d_stim.delete(); d_q.delete(); if_q.delete(); order_q.delete();
        flush = 1'b0; hold_ack = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("post_rst_mem_req", mem_req, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-ported word memory between the CPU's instruction-fetch (IF) requester and data-access (MEM-stage) requester.
- Sequences each access with a req/ack handshake and drives a stall to the pipeline while any request is outstanding.
- Default priority is data over fetch. A starvation guard bounds how long fetch can wait.
- Keeps a saturating stall-cycle counter that the bench reads for stall statistics.

Parameters:
ADDR_W, 32, address width for both requesters and the memory
DATA_W, 32, data word width
STARVE_LIMIT, 4, consecutive D grants with fetch pending before fetch is forced to win
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  enables new grants; low means no new grant (in-flight access completes)
if_req_i  in  1  fetch request, held high until if_ack_o
if_addr_i  in  ADDR_W  fetch byte address
if_rdata_o  out  DATA_W  fetch read data; valid while if_ack_o=1, held afterwards
if_ack_o  out  1  one-cycle fetch completion pulse
d_req_i  in  1  data request, held high until d_ack_o
d_we_i  in  1  1=write, 0=read
d_addr_i  in  ADDR_W  data byte address
d_wdata_i  in  DATA_W  write data
d_rdata_o  out  DATA_W  data read data; valid while d_ack_o=1, held afterwards
d_ack_o  out  1  one-cycle data completion pulse
mem_req_o  out  1  memory access request
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data; sampled when mem_ack_i=1
mem_ack_i  in  1  memory completion; may assert in the first mem_req_o cycle
stall_o  out  1  pipeline stall
stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating

Behaviour:
- Reset (rst_i=0, asynchronous) forces the following, taking effect immediately mid-transaction:
  - state=IDLE
  - all outputs 0, including rdata regs and stall_cnt_o
  - starve_cnt=0
- FSM states: IDLE, GNT_I, GNT_D. All memory-side outputs are registered.
- Eligibility: a requester is eligible when start_i=1, its req=1 and its own ack_o=0 this cycle. Masking req during its ack cycle prevents re-granting a request the requester is still holding.
- IDLE with both eligible:
  - D wins, unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - The winner's address/we/wdata are latched.
  - mem_req_o=1 from the next cycle.
  - Fetch is always mem_we_o=0, mem_wdata_o=0.
- IDLE with one eligible: that one wins.
- IDLE with none eligible: stay in IDLE.
- GNT_x:
  - Hold mem_req_o and the latched mem_* stable until mem_ack_i=1.
  - On that edge: capture mem_rdata_i into x_rdata_o (writes also capture it; don't-care), pulse x_ack_o=1 for the next cycle only, drop mem_req_o, go to IDLE.
- Arbitration latency:
  - Minimum access is 2 cycles from request-visible to ack (req at edge0, mem_req_o cycle1, ack_o cycle2).
  - Back-to-back grants: a new grant can be decided in the ack cycle (IDLE), giving mem_req_o again the cycle after.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while if_req_i eligible.
  - Clears on any I grant.
  - Clears on any IDLE cycle with if_req_i=0.
- start_i falling during GNT_x: the access completes normally with ack. No further grants until start_i=1.
- stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). It is combinational and ungated by start_i.
- stall_cnt_o: +1 each cycle stall_o=1; holds at 2^CNT_W-1.
- Requester changing addr/wdata while pending is ignored after grant (latched values are used).
- Dropping req before ack is a protocol violation. The granted access still completes and acks.

Test Plan:
- Reset mid-access: assert rst_i=0 during GNT_D -> same cycle mem_req_o=0, d_ack_o=0, stall_cnt_o=0. After release, state IDLE, no spurious ack.
- Single fetch, zero-wait memory: if_req_i=1, if_addr_i=0x0000_0006, mem_ack_i tied 1, mem_rdata_i=0x2008_0005 ->
  - mem_addr_o=0x0000_0004, mem_we_o=0 in cycle1;
  - if_ack_o=1 and if_rdata_o=0x2008_0005 in cycle2 only;
  - stall_cnt_o=2.
- Simultaneous requests: if_req_i=d_req_i=1, d_we_i=1, d_addr_i=0x10, d_wdata_i=0xDEAD_BEEF, memory 3-wait ->
  - data granted first with mem_we_o=1, mem_wdata_o=0xDEAD_BEEF held 4 cycles;
  - d_ack_o, then fetch granted the following cycle.
- Starvation guard, STARVE_LIMIT=4: d_req_i re-asserted immediately after every ack, if_req_i held high ->
  - exactly 4 D grants, then 1 I grant, then D resumes;
  - starve_cnt returns to 0.
- start_i gating: start_i=0 with both requests high -> mem_req_o stays 0, stall_o=1, stall_cnt_o increments each cycle. Drop start_i mid-GNT_I -> that fetch still acks, then no grant.
- Saturation, CNT_W=4: stall held 20 cycles -> stall_cnt_o stops at 15.
